// File: rtl/mlp_sample_feeder_if.sv
// mlp_sample_feeder_if: feature-in, mlp-side and result-out signals of the sample feeder
//   master: feeder side (drives wr_ready, mlp_data, mlp_new_data, res_valid/bit/tag/err)
//   slave : environment side (drives flush, wr_valid/data, mlp_output_ready/output, res_ready)
interface mlp_sample_feeder_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_FEATURES = 2,
    parameter int TAG_W        = 8
);
    logic                                     flush;
    logic                                     wr_valid;
    logic                                     wr_ready;
    logic [DATA_WIDTH-1:0]                    wr_data;
    logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0]  mlp_data;
    logic                                     mlp_new_data;
    logic                                     mlp_output_ready;
    logic                                     mlp_output;
    logic                                     res_valid;
    logic                                     res_ready;
    logic                                     res_bit;
    logic [TAG_W-1:0]                         res_tag;
    logic                                     res_err;
    modport master (
        input  flush, wr_valid, wr_data, mlp_output_ready, mlp_output, res_ready,
        output wr_ready, mlp_data, mlp_new_data, res_valid, res_bit, res_tag, res_err
    );
    modport slave (
        output flush, wr_valid, wr_data, mlp_output_ready, mlp_output, res_ready,
        input  wr_ready, mlp_data, mlp_new_data, res_valid, res_bit, res_tag, res_err
    );
endinterface

// File: rtl/mlp_sample_feeder.sv
// mlp_sample_feeder: assembles feature words into samples, queues them, feeds mlp one at a time
//   clk, rst (async, active-high)
//   bus.master: flush, wr_valid/wr_ready/wr_data in, mlp_data/mlp_new_data out,
//               mlp_output_ready/mlp_output in, res_valid/res_ready/res_bit/res_tag/res_err out
//   MLP_FEEDER_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT_CYC cycles that flags res_err
module mlp_sample_feeder #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_FEATURES = 2,
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 8,
    parameter int TIMEOUT_CYC  = 64
) (
    input logic clk,
    input logic rst,
    mlp_sample_feeder_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = NUM_FEATURES > 1 ? $clog2(NUM_FEATURES) : 1;
    typedef logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] sample_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
    state_t state, nxt;
    sample_t q [DEPTH];
    sample_t stage, full;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [IW-1:0] idx;
    logic [TAG_W-1:0] tag_cnt;
    logic accept, last, commit, pop, expire;
    assign bus.wr_ready = count < (AW+1)'(DEPTH);
    assign accept = bus.wr_valid & bus.wr_ready;
    assign last = idx == IW'(NUM_FEATURES - 1);
    assign commit = accept & last & ~bus.flush;
    assign pop = state == IDLE && count != '0 && !bus.flush;
    // staging slots with the incoming word merged in, so the last word commits on its own edge
    always_comb begin
        full = stage;
        full[idx] = bus.wr_data;
    end
    always_ff @(posedge clk)
        if (commit) q[wptr] <= full;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            idx <= '0;
            stage <= '0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            idx <= '0;
        end else begin
            if (accept) stage <= full;
            if (accept) idx <= last ? '0 : idx + 1'b1;
            if (commit) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(commit) - (AW+1)'(pop);
        end
`ifdef MLP_FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo;
    always_ff @(posedge clk or posedge rst)
        if (rst) tmo <= '0;
        else tmo <= state == WAIT ? tmo + 1'b1 : '0;
    assign expire = state == WAIT && tmo == CW'(TIMEOUT_CYC - 1);
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = pop ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = bus.mlp_output_ready || expire ? EMIT : WAIT;
            EMIT:    nxt = bus.res_ready ? IDLE : EMIT;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.mlp_new_data = state == ISSUE;
        bus.res_valid = state == EMIT;
    end
    // a real strobe beats a same-cycle expiry; an expiry reports bit 0 with the error flag
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.mlp_data <= '0;
            bus.res_bit <= 1'b0;
            bus.res_tag <= '0;
            bus.res_err <= 1'b0;
            tag_cnt <= '0;
        end else begin
            if (pop) begin
                bus.mlp_data <= q[rptr];
                bus.res_tag <= tag_cnt;
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (state == WAIT && (bus.mlp_output_ready || expire)) begin
                bus.res_bit <= bus.mlp_output_ready & bus.mlp_output;
                bus.res_err <= expire & ~bus.mlp_output_ready;
            end
        end
endmodule

// File: tb/tb_mlp_sample_feeder.sv
// tb_mlp_sample_feeder: directed bench for mlp_sample_feeder with a behavioural mlp responder
module tb_mlp_sample_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mlp_sample_feeder_if #(16, 2, 8) f();
    mlp_sample_feeder_if #(16, 2, 2) g();
    mlp_sample_feeder #(.DATA_WIDTH(16), .NUM_FEATURES(2), .DEPTH(4), .TAG_W(8), .TIMEOUT_CYC(8))
        dut (.clk(clk), .rst(rst), .bus(f));
    mlp_sample_feeder #(.DATA_WIDTH(16), .NUM_FEATURES(2), .DEPTH(4), .TAG_W(2), .TIMEOUT_CYC(8))
        dut2 (.clk(clk), .rst(rst), .bus(g));
    assign g.flush = f.flush;
    assign g.wr_valid = f.wr_valid;
    assign g.wr_data = f.wr_data;
    assign g.mlp_output_ready = f.mlp_output_ready;
    assign g.mlp_output = f.mlp_output;
    assign g.res_ready = f.res_ready;
    int ncmp = 0;
    int nerr = 0;
    int pulses = 0;
    int model_d = 5;
    bit model_en = 1'b1;
    bit in_flight = 1'b0;
    bit low_seen = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] rtag[$], rtag2[$], rbit[$], rerr[$], rdat[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_bit(input logic [15:0] w0, input logic [15:0] w1);
        return {31'b0, ~^{w1, w0}};
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [15:0] d);
        int n = 0;
        f.wr_valid = 1'b1;
        f.wr_data = d;
        while (!f.wr_ready && n < 200) begin
            tick;
            n++;
        end
        if (n >= 200) check("push_stall", 32'(n), 0);
        tick;
        f.wr_valid = 1'b0;
    endtask
    task automatic sample(input logic [15:0] w0, input logic [15:0] w1);
        push(w0);
        push(w1);
    endtask
    task automatic do_reset;
        rst = 1'b1;
        #1;
        check("rst_wr_ready", f.wr_ready, 1);
        check("rst_res_valid", f.res_valid, 0);
        check("rst_new_data", f.mlp_new_data, 0);
        check("rst_mlp_data", f.mlp_data, 0);
        check("rst_res_tag", f.res_tag, 0);
        check("rst_res_bit", f.res_bit, 0);
        check("rst_res_err", f.res_err, 0);
        tick;
        tick;
        rst = 1'b0;
        rtag.delete(); rtag2.delete(); rbit.delete(); rerr.delete(); rdat.delete();
        pulses = 0;
        in_flight = 1'b0;
        low_seen = 1'b0;
    endtask
    task automatic wait_res(input int n, input int limit);
        int t = 0;
        while (rtag.size() < n && t < limit) begin
            tick;
            t++;
        end
        check("wait_res", 32'(rtag.size()), 32'(n));
    endtask
    task automatic wait_valid(input int limit);
        int t = 0;
        while (!f.res_valid && t < limit) begin
            tick;
            t++;
        end
        check("wait_valid", f.res_valid, 1);
    endtask
    initial forever begin
        @(negedge clk);
        if (f.mlp_new_data === 1'b1) begin
            pulses++;
            check("overlap", in_flight, 0);
            in_flight = 1'b1;
            held = f.mlp_data;
            rdat.push_back(f.mlp_data);
        end
        if (f.mlp_output_ready === 1'b1) check("data_hold", f.mlp_data, held);
        if (f.res_valid === 1'b1 && f.res_ready === 1'b1) begin
            rtag.push_back(32'(f.res_tag));
            rtag2.push_back(32'(g.res_tag));
            rbit.push_back(32'(f.res_bit));
            rerr.push_back(32'(f.res_err));
            in_flight = 1'b0;
        end
        if (f.wr_ready === 1'b0) low_seen = 1'b1;
    end
    initial begin
        f.mlp_output_ready = 1'b0;
        f.mlp_output = 1'b0;
        forever begin
            @(negedge clk);
            if (f.mlp_new_data === 1'b1 && model_en) begin
                repeat (model_d) @(posedge clk);
                #1;
                f.mlp_output_ready = 1'b1;
                f.mlp_output = ~^f.mlp_data;
                @(posedge clk);
                #1;
                f.mlp_output_ready = 1'b0;
                f.mlp_output = 1'b0;
            end
        end
    end
    logic [15:0] w0 [5] = '{16'h0001, 16'h0003, 16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] w1 [5] = '{16'h0002, 16'h0000, 16'h0001, 16'h5678, 16'h0000};
    initial begin
        int k;
        f.flush = 1'b0;
        f.wr_valid = 1'b0;
        f.wr_data = '0;
        f.res_ready = 1'b0;
        do_reset;
        // single sample: issue latency, held data, result fields
        model_d = 5;
        sample(16'h1000, 16'h0800);
        check("t1_idle", f.mlp_new_data, 0);
        tick;
        check("t1_issue", f.mlp_new_data, 1);
        check("t1_data", f.mlp_data, 32'h0800_1000);
        wait_valid(50);
        check("t1_bit", f.res_bit, 1);
        check("t1_tag", f.res_tag, 0);
        check("t1_err", f.res_err, 0);
        check("t1_pulses", 32'(pulses), 1);
        f.res_ready = 1'b1;
        tick;
        check("t1_handshake", 32'(rtag.size()), 1);
        check("t1_done", f.res_valid, 0);
        // five back-to-back samples, queue fills, tags in order, 2-bit tags wrap
        do_reset;
        f.res_ready = 1'b1;
        model_d = 6;
        for (int i = 0; i < 5; i++) sample(w0[i], w1[i]);
        wait_res(5, 400);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_tag%0d", i), rtag[i], 32'(i));
            check($sformatf("t2_tag2_%0d", i), rtag2[i], 32'(i % 4));
            check($sformatf("t2_bit%0d", i), rbit[i], exp_bit(w0[i], w1[i]));
            check($sformatf("t2_dat%0d", i), rdat[i], {w1[i], w0[i]});
            check($sformatf("t2_err%0d", i), rerr[i], 0);
        end
        check("t2_full", 32'(low_seen), 1);
        // result held in EMIT with res_ready low, nothing issued meanwhile
        do_reset;
        f.res_ready = 1'b0;
        model_d = 5;
        sample(16'h0011, 16'h0022);
        sample(16'h0100, 16'h0001);
        wait_valid(60);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("t3_valid", f.res_valid, 1);
            check("t3_tag", f.res_tag, 0);
            check("t3_bit", f.res_bit, exp_bit(16'h0011, 16'h0022));
            check("t3_no_pulse", f.mlp_new_data, 0);
        end
        check("t3_pulses", 32'(pulses), 1);
        f.res_ready = 1'b1;
        wait_res(2, 100);
        check("t3_tag1", rtag[1], 1);
        check("t3_bit1", rbit[1], exp_bit(16'h0100, 16'h0001));
        // flush during WAIT with two queued samples and a partial one
        do_reset;
        f.res_ready = 1'b1;
        model_d = 6;
        sample(16'h0005, 16'h0006);
        sample(16'h0007, 16'h0008);
        sample(16'h0009, 16'h000A);
        push(16'hAAAA);
        f.flush = 1'b1;
        tick;
        f.flush = 1'b0;
        sample(16'h0003, 16'h0004);
        wait_res(2, 200);
        repeat (40) tick;
        check("t4_count", 32'(rtag.size()), 2);
        check("t4_dat0", rdat[0], 32'h0006_0005);
        check("t4_tag0", rtag[0], 0);
        check("t4_bit0", rbit[0], exp_bit(16'h0005, 16'h0006));
        check("t4_dat1", rdat[1], 32'h0004_0003);
        check("t4_tag1", rtag[1], 1);
        check("t4_bit1", rbit[1], exp_bit(16'h0003, 16'h0004));
        // mlp never answers
        do_reset;
        f.res_ready = 1'b0;
        model_en = 1'b0;
        sample(16'h0001, 16'h0000);
        tick;
        check("t6_issue", f.mlp_new_data, 1);
        k = 0;
        while (!f.res_valid && k < 40) begin
            tick;
            k++;
        end
`ifdef MLP_FEEDER_TIMEOUT_EN
        check("t6_latency", 32'(k), 9);
        check("t6_valid", f.res_valid, 1);
        check("t6_err", f.res_err, 1);
        check("t6_bit", f.res_bit, 0);
`else
        check("t6_latency", 32'(k), 40);
        check("t6_valid", f.res_valid, 0);
        check("t6_err", f.res_err, 0);
`endif
        do_reset;
        model_en = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
